fp32_to_fp16_conv: RTL

Pipelined narrowing converter from IEEE-754 binary32 to binary16 with round-to-nearest-even. Sits at the output of the FP16 multiply/accumulate path: FP32 products and partial sums coming out of the systolic array are converted back to FP16 before write-back over AXI. It is the return direction of the FP16→FP32 multiplier front end. It uses a valid/ready streaming handshake with full throughput and lossless backpressure.

---
 rtl/fp_conv_pkg.sv | 45 ++++
 rtl/fp_rne_round.sv | 17 +
 rtl/fp32_to_fp16_conv.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fp_conv_pkg.sv
// Shared field widths, biases, canonical encodings and stage payloads for the FP32->FP16 converter.
// FP16_SUBNORMAL_EN adds the S1 shift amount and subnormal-path constants.
package fp_conv_pkg;

   localparam int unsigned FP32_EXP_W   = 8;
   localparam int unsigned FP32_MAN_W   = 23;
   localparam int unsigned FP16_EXP_W   = 5;
   localparam int unsigned FP16_MAN_W   = 10;
   localparam int unsigned FP32_BIAS    = 127;
   localparam int unsigned FP16_BIAS    = 15;
   localparam int unsigned BIAS_DELTA   = FP32_BIAS - FP16_BIAS;
   localparam int unsigned E32_NORM_MIN = BIAS_DELTA + 1;
   localparam int unsigned E32_OVF      = BIAS_DELTA + 31;

`ifdef FP16_SUBNORMAL_EN
   // Total right shift of {1,m32} is (113 - e32) + 13 = 126 - e32, range 14..24
   localparam int unsigned SH_W           = 5;
   localparam int unsigned E32_SUB_MIN    = BIAS_DELTA - FP16_MAN_W;
   localparam int unsigned SUB_SHIFT_BASE = E32_NORM_MIN + (FP32_MAN_W - FP16_MAN_W);
`endif

   localparam logic [15:0] QNAN16 = 16'h7E00;
   localparam logic [15:0] INF16  = 16'h7C00;

   typedef enum logic [2:0] {
      FP_ZERO,
      FP_SUB,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_e;

   // lost: INF from a finite input (overflow) or ZERO from a nonzero input (underflow)
   typedef struct packed {
      logic                  sign;
      fp_class_e             cls;
      logic [FP16_EXP_W-1:0] e16;
      logic [FP32_MAN_W-1:0] man;
`ifdef FP16_SUBNORMAL_EN
      logic [SH_W-1:0]       sh;
`endif
      logic                  lost;
   } s1_t;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even of a {mantissa, guard, sticky} bundle.
module fp_rne_round #(
   parameter int unsigned W = 10
) (
   input  logic [W-1:0] mant,
   input  logic         guard,
   input  logic         sticky,
   output logic [W-1:0] mant_rnd_c,
   output logic         carry_c
);

   logic round_up;

   assign round_up             = guard & (sticky | mant[0]);
   assign {carry_c, mant_rnd_c} = {1'b0, mant} + (W+1)'(round_up);

endmodule

// File: rtl/fp32_to_fp16_conv.sv
// Two-stage FP32->FP16 narrowing converter (RNE) with valid/ready backpressure and a sideband tag.
// Define FP16_SUBNORMAL_EN to produce FP16 subnormals instead of flushing them to zero.
module fp32_to_fp16_conv
   import fp_conv_pkg::*;
#(
   parameter int unsigned TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_overflow,
   output logic             out_underflow,
   output logic             out_inexact
);

   localparam int unsigned GRD = FP32_MAN_W - FP16_MAN_W - 1;

   logic                  s1_valid;
   s1_t                   s1_d, s1_q;
   logic [TAG_W-1:0]      s1_tag;
   logic                  s1_adv, s2_adv;
   logic [FP32_EXP_W-1:0] e32;
   logic [FP32_MAN_W-1:0] m32;

   logic [FP16_MAN_W-1:0] norm_mant;
   logic                  norm_carry;
   logic                  norm_guard, norm_sticky;
   logic [FP16_EXP_W-1:0] e_inc;

   logic [15:0] res_d;
   logic        ovf_d, unf_d, inx_d;

   assign s2_adv   = !out_valid | out_ready;
   assign s1_adv   = !s1_valid | s2_adv;
   assign in_ready = s1_adv;

   assign e32 = in_data[30:23];
   assign m32 = in_data[22:0];

   // S1: classify and prepare exponent / shift
   always_comb begin
      s1_d      = '0;
      s1_d.sign = in_data[31];
      s1_d.man  = m32;
      s1_d.cls  = FP_ZERO;
      if (e32 == '1) begin
         s1_d.cls = (m32 != '0) ? FP_NAN : FP_INF;
      end else if (e32 >= FP32_EXP_W'(E32_OVF)) begin
         s1_d.cls  = FP_INF;
         s1_d.lost = 1'b1;
      end else if (e32 >= FP32_EXP_W'(E32_NORM_MIN)) begin
         s1_d.cls = FP_NORM;
         s1_d.e16 = FP16_EXP_W'(e32 - FP32_EXP_W'(BIAS_DELTA));
`ifdef FP16_SUBNORMAL_EN
      end else if (e32 >= FP32_EXP_W'(E32_SUB_MIN)) begin
         s1_d.cls = FP_SUB;
         s1_d.sh  = SH_W'(FP32_EXP_W'(SUB_SHIFT_BASE) - e32);
`endif
      end else begin
         s1_d.lost = (in_data[30:0] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
         s1_tag   <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_q   <= s1_d;
            s1_tag <= in_tag;
         end
      end
   end

   assign norm_guard  = s1_q.man[GRD];
   assign norm_sticky = |s1_q.man[GRD-1:0];

   fp_rne_round #(.W(FP16_MAN_W)) u_rnd_norm (
      .mant       (s1_q.man[FP32_MAN_W-1 -: FP16_MAN_W]),
      .guard      (norm_guard),
      .sticky     (norm_sticky),
      .mant_rnd_c (norm_mant),
      .carry_c    (norm_carry)
   );

   assign e_inc = s1_q.e16 + FP16_EXP_W'(norm_carry);

`ifdef FP16_SUBNORMAL_EN
   localparam int unsigned SIG_W = FP32_MAN_W + 1;

   logic [SIG_W-1:0]      sub_sig;
   logic [SH_W-1:0]       sub_gpos;
   logic [FP16_MAN_W-1:0] sub_mant, sub_mant_rnd;
   logic                  sub_guard, sub_sticky, sub_carry;

   // Denormalising shifter: guard is the last bit shifted out, sticky everything below it
   assign sub_sig    = {1'b1, s1_q.man};
   assign sub_gpos   = s1_q.sh - SH_W'(1);
   assign sub_mant   = FP16_MAN_W'(sub_sig >> s1_q.sh);
   assign sub_guard  = sub_sig[sub_gpos];
   assign sub_sticky = |(sub_sig & ((SIG_W'(1) << sub_gpos) - SIG_W'(1)));

   fp_rne_round #(.W(FP16_MAN_W)) u_rnd_sub (
      .mant       (sub_mant),
      .guard      (sub_guard),
      .sticky     (sub_sticky),
      .mant_rnd_c (sub_mant_rnd),
      .carry_c    (sub_carry)
   );
`endif

   // S2: round, pack, flags; underflow means tiny after rounding and inexact
   always_comb begin
      res_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
      case (s1_q.cls)
         FP_NAN: res_d = {s1_q.sign, QNAN16[14:0]};
         FP_INF: begin
            res_d = {s1_q.sign, INF16[14:0]};
            ovf_d = s1_q.lost;
            inx_d = s1_q.lost;
         end
         FP_NORM: begin
            inx_d = norm_guard | norm_sticky;
            if (e_inc == '1) begin
               res_d = {s1_q.sign, INF16[14:0]};
               ovf_d = 1'b1;
            end else begin
               res_d = {s1_q.sign, e_inc, norm_mant};
            end
         end
`ifdef FP16_SUBNORMAL_EN
         FP_SUB: begin
            inx_d = sub_guard | sub_sticky;
            unf_d = inx_d & ~sub_carry;
            res_d = {s1_q.sign, (FP16_EXP_W-1)'(0), sub_carry, sub_mant_rnd};
         end
`endif
         default: begin
            res_d = {s1_q.sign, 15'd0};
            unf_d = s1_q.lost;
            inx_d = s1_q.lost;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_tag       <= '0;
         out_overflow  <= 1'b0;
         out_underflow <= 1'b0;
         out_inexact   <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data      <= res_d;
            out_tag       <= s1_tag;
            out_overflow  <= ovf_d;
            out_underflow <= unf_d;
            out_inexact   <= inx_d;
         end
      end
   end

endmodule
